// File: rtl/config_seq_pkg.sv
// Shared types and field widths for the configuration sequencer and its payload buffer.
package config_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_HDR_ID,
        S_HDR_LEN,
        S_LOAD,
        S_BURST,
        S_GAP,
        S_DONE
    } state_t;

    localparam int ID_W   = 8;
    localparam int LEN_W  = 8;
    localparam int DATA_W = 8;

    localparam logic [ID_W-1:0] DEFAULT_IDLE_ID = 8'hFF;

endpackage

// File: rtl/config_byte_buffer.sv
// Payload store for one record: written in arrival order, read back in the same order.
module config_byte_buffer
    import config_seq_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  wr_sel;
    logic [IDX_W-1:0]  rd_idx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    assign rd_idx = rd_ptr_q[IDX_W-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en && (wr_ptr_q != PTR_W'(DEPTH)))
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en && (rd_ptr_q != PTR_W'(DEPTH)))
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // A byte written this cycle is forwarded so a one-byte record can start its burst immediately.
    always_comb begin
        rd_data = '0;
        if (wr_en && (wr_ptr_q == rd_ptr_q))
            rd_data = wr_data;
        else if (rd_ptr_q < PTR_W'(DEPTH))
            rd_data = mem_q[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++)
                if (wr_sel[i])
                    mem_q[i] <= wr_data;
        end
    end

endmodule

// File: rtl/config_sequencer.sv
// Turns a host byte stream of {id, len, payload} records into contiguous per-block config bursts.
module config_sequencer
    import config_seq_pkg::*;
#(
    parameter int               MAX_CHAINS   = 4,
    parameter int               MAX_PAYLOAD  = 32,
    parameter int               DRAIN_CYCLES = 4,
    parameter logic [ID_W-1:0]  IDLE_ID      = DEFAULT_IDLE_ID
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tracing_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              tracing,
    output logic [ID_W-1:0]   configId,
    output logic [DATA_W-1:0] configData,
    output logic              busy,
    output logic              done,
    output logic              error
);

    generate
        if (MAX_PAYLOAD < 5 * MAX_CHAINS || DRAIN_CYCLES < 1) begin : g_param_check
            $error("config_sequencer: MAX_PAYLOAD must be >= 5*MAX_CHAINS and DRAIN_CYCLES >= 1");
        end
    endgenerate

    state_t             state_q, state_d;
    logic               tracing_q, tracing_d;
    logic               in_ready_q, in_ready_d;
    logic [ID_W-1:0]    config_id_q, config_id_d;
    logic [DATA_W-1:0]  config_data_q, config_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [ID_W-1:0]    target_id_q, target_id_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               buf_clr, buf_wr_en, buf_rd_en;
    logic [DATA_W-1:0]  buf_rd_data;

    assign accept = in_valid && in_ready_q;

    config_byte_buffer #(
        .DEPTH (MAX_PAYLOAD)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .clr     (buf_clr),
        .wr_en   (buf_wr_en),
        .wr_data (in_data),
        .rd_en   (buf_rd_en),
        .rd_data (buf_rd_data)
    );

    // Outputs are registered from the next state, so each flop already shows the value for the state it enters.
    always_comb begin
        state_d       = state_q;
        error_d       = error_q;
        target_id_d   = target_id_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        buf_clr       = 1'b0;
        buf_wr_en     = 1'b0;
        buf_rd_en     = 1'b0;
        config_id_d   = IDLE_ID;
        config_data_d = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && !tracing_req) begin
                    state_d = S_DRAIN;
                    error_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt_q == LEN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = S_HDR_ID;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HDR_ID: begin
                buf_clr = 1'b1;
                if (accept) begin
                    if (in_data == IDLE_ID) begin
                        state_d = S_DONE;
                    end else begin
                        target_id_d = in_data;
                        state_d     = S_HDR_LEN;
                    end
                end
            end
            S_HDR_LEN: begin
                if (accept) begin
                    if (in_data == '0) begin
                        state_d = S_HDR_ID;
                    end else if (in_data > LEN_W'(MAX_PAYLOAD)) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        len_d   = in_data;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    buf_wr_en = 1'b1;
                    if (cnt_q == len_q - 8'd1) begin
                        state_d       = S_BURST;
                        cnt_d         = '0;
                        buf_rd_en     = 1'b1;
                        config_id_d   = target_id_q;
                        config_data_d = buf_rd_data;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_BURST: begin
                if (cnt_q == len_q - 8'd1) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d         = cnt_q + 8'd1;
                    buf_rd_en     = 1'b1;
                    config_id_d   = target_id_q;
                    config_data_d = buf_rd_data;
                end
            end
            S_GAP:   state_d = S_HDR_ID;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        tracing_d  = (state_d == S_IDLE) && tracing_req;
        in_ready_d = (state_d == S_HDR_ID) || (state_d == S_HDR_LEN) || (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tracing_q     <= 1'b0;
            in_ready_q    <= 1'b0;
            config_id_q   <= IDLE_ID;
            config_data_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            target_id_q   <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            tracing_q     <= tracing_d;
            in_ready_q    <= in_ready_d;
            config_id_q   <= config_id_d;
            config_data_q <= config_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            target_id_q   <= target_id_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign tracing    = tracing_q;
    assign configId   = config_id_q;
    assign configData = config_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_config_sequencer.sv
// Directed sessions against config_sequencer; a monitor checks bursts and done pulses from scoreboard queues.
module tb_config_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tracing_req;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tracing;
    logic [7:0] configId;
    logic [7:0] configData;
    logic       busy;
    logic       done;
    logic       error;

    config_sequencer #(
        .MAX_CHAINS   (4),
        .MAX_PAYLOAD  (32),
        .DRAIN_CYCLES (4),
        .IDLE_ID      (8'hFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tracing_req (tracing_req),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .tracing     (tracing),
        .configId    (configId),
        .configData  (configData),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    logic exp_done_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   drain_seen = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops expected burst bytes and done results whenever the DUT presents them.
    initial begin : monitor
        bit   mid_rec;
        bit   after_last;
        exp_t e;
        mid_rec    = 1'b0;
        after_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                mid_rec    = 1'b0;
                after_last = 1'b0;
            end else begin
                if (configId != 8'hFF) begin
                    if (after_last)
                        fail("gap_after_record", configId, 8'hFF);
                    after_last = 1'b0;
                    if (exp_q.size() == 0) begin
                        fail("unexpected_burst", {configId, configData}, 16'hFF00);
                        mid_rec = 1'b0;
                    end else begin
                        e = exp_q.pop_front();
                        $display("burst id=%0h data=%0h (expect %0h/%0h)", configId, configData, e.id, e.data);
                        check("burst_id", configId, e.id);
                        check("burst_data", configData, e.data);
                        mid_rec    = !e.last;
                        after_last = e.last;
                    end
                end else begin
                    if (mid_rec)
                        fail("burst_gap", configId, exp_q.size() > 0 ? exp_q[0].id : 8'h00);
                    if (busy)
                        check("idle_data_zero", configData, 8'h00);
                    mid_rec    = 1'b0;
                    after_last = 1'b0;
                end
                if (done) begin
                    if (exp_done_q.size() == 0) begin
                        fail("unexpected_done", done, 1'b0);
                    end else begin
                        logic exp_err;
                        exp_err = exp_done_q.pop_front();
                        $display("done error=%0b (expect %0b)", error, exp_err);
                        check("done_error", error, exp_err);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
            if (busy && !in_ready && !tracing)
                drain_seen++;
        end
        if (!in_ready)
            fail("send_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rec(input logic [7:0] id, input logic [7:0] len, input logic [7:0] base,
                            input logic [7:0] step, input bit bubble, input bit push);
        logic [7:0] d;
        if (push) begin
            for (int i = 0; i < int'(len); i++) begin
                d = base + 8'(i) * step;
                exp_q.push_back('{id: id, data: d, last: (i == int'(len) - 1)});
            end
        end
        send(id);
        send(len);
        for (int i = 0; i < int'(len); i++) begin
            if (bubble && i > 0)
                @(posedge clk);
            send(base + 8'(i) * step);
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (busy && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (busy)
            fail("idle_timeout", busy, 1'b0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int w;
        reset       = 1'b1;
        tracing_req = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tracing", tracing, 1'b0);
        check("rst_configId", configId, 8'hFF);
        check("rst_configData", configData, 8'h00);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Idle passthrough of tracing_req with one cycle of latency
        tracing_req = 1'b1;
        check("trace_before_edge", tracing, 1'b0);
        @(negedge clk);
        check("trace_on", tracing, 1'b1);
        check("trace_busy", busy, 1'b0);
        check("trace_configId", configId, 8'hFF);
        tracing_req = 1'b0;
        @(negedge clk);
        check("trace_off", tracing, 1'b0);

        // Single 20-byte record
        drain_seen = 0;
        exp_done_q.push_back(1'b0);
        send_rec(8'd3, 8'd20, 8'h00, 8'h01, 1'b0, 1'b1);
        check("drain_cycles", drain_seen, 4);
        send(8'hFF);
        wait_idle();
        check("single_busy_low", busy, 1'b0);

        // Back-to-back records to the same id
        exp_done_q.push_back(1'b0);
        send_rec(8'd5, 8'd2, 8'hAA, 8'h11, 1'b0, 1'b1);
        send_rec(8'd5, 8'd1, 8'hCC, 8'h00, 1'b0, 1'b1);
        send(8'hFF);
        wait_idle();

        // Host bubbles between payload bytes
        exp_done_q.push_back(1'b0);
        send_rec(8'd2, 8'd4, 8'h11, 8'h11, 1'b1, 1'b1);
        send(8'hFF);
        wait_idle();

        // Oversized length aborts with error
        exp_done_q.push_back(1'b1);
        send(8'd7);
        send(8'd33);
        wait_idle();
        check("error_sticky", error, 1'b1);
        check("error_configId", configId, 8'hFF);

        // Zero length record is skipped; next header accepted; error clears
        exp_done_q.push_back(1'b0);
        send(8'd9);
        send(8'd0);
        send_rec(8'd4, 8'd1, 8'h5A, 8'h00, 1'b0, 1'b1);
        check("error_cleared", error, 1'b0);
        send(8'hFF);
        wait_idle();

        // Reset in the middle of a 10-byte burst
        mon_en = 1'b0;
        send_rec(8'd5, 8'd10, 8'h00, 8'h01, 1'b0, 1'b0);
        w = 0;
        while (!(configId == 8'd5 && configData == 8'h01) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("midburst_byte2_seen", {configId, configData}, 16'h0501);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_configId", configId, 8'hFF);
        check("midrst_configData", configData, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        exp_done_q.push_back(1'b0);
        send_rec(8'd6, 8'd3, 8'h0A, 8'h01, 1'b0, 1'b1);
        send(8'hFF);
        wait_idle();

        repeat (3) @(negedge clk);
        check("burst_queue_empty", exp_q.size(), 0);
        check("done_queue_empty", exp_done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/config_sequencer.md
CONFIG_SEQUENCER -- requirements
Module: config_sequencer

Interface
REQ-001 SHALL have parameter MAX_CHAINS, default 4, meaning the chain count of the downstream firmware-configurable blocks.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 32, meaning payload buffer depth in bytes; it SHALL be >= 5*MAX_CHAINS.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, meaning the number of cycles tracing is held low before the first config byte.
REQ-004 SHALL have parameter IDLE_ID, default 8'hFF, meaning the configId that no downstream block owns.
REQ-005 Ports (name, direction, width, meaning):
 clk  input  1  single clock, all logic on rising edge
 reset  input  1  synchronous, active-high
 tracing_req  input  1  host requests tracing mode
 in_valid  input  1  host config byte valid
 in_data  input  8  host config byte
 in_ready  output  1  byte accepted when in_valid&&in_ready
 tracing  output  1  tracing enable broadcast to datapath blocks
 configId  output  8  target block id broadcast
 configData  output  8  config byte broadcast
 busy  output  1  session in progress
 done  output  1  one-cycle session-complete pulse
 error  output  1  sticky until next session start

Function
REQ-006 Host stream SHALL be records {id, len, payload[len]}; a record whose id equals IDLE_ID SHALL end the session.
REQ-007 States SHALL be IDLE, DRAIN, HDR_ID, HDR_LEN, LOAD, BURST, GAP, DONE.
REQ-008 IDLE: tracing = tracing_req (registered, 1-cycle latency), in_ready=0; on in_valid && !tracing_req -> DRAIN, clear error.
REQ-009 In all states other than IDLE, tracing SHALL be 0; tracing_req changes outside IDLE SHALL be ignored.
REQ-010 DRAIN SHALL last exactly DRAIN_CYCLES cycles with in_ready=0, then -> HDR_ID.
REQ-011 HDR_ID: in_ready=1; accepted byte == IDLE_ID -> DONE; otherwise latch as target id -> HDR_LEN.
REQ-012 HDR_LEN: in_ready=1; len==0 -> HDR_ID; len>MAX_PAYLOAD -> set error, -> DONE; otherwise latch len -> LOAD.
REQ-013 LOAD: in_ready=1; store accepted bytes in order; after the len-th byte -> BURST; host bubbles (in_valid=0) SHALL be tolerated.
REQ-014 BURST: in_ready=0; configId=target id and configData=buffer[k] SHALL appear for exactly len consecutive cycles, k=0..len-1, with no gaps.
REQ-015 GAP: exactly one cycle with configId=IDLE_ID, then -> HDR_ID, so that downstream byte counters restart for back-to-back records to the same id.
REQ-016 DONE: done=1 for one cycle, -> IDLE.
REQ-017 Outside BURST, configId SHALL be IDLE_ID and configData SHALL be 0.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 The burst counter and length SHALL be 8 bits wide; no wrap is possible because len<=MAX_PAYLOAD.

Reset
REQ-020 On reset the state SHALL be IDLE with tracing=0, configId=IDLE_ID, configData=0, in_ready=0, busy=0, done=0, error=0, and counters at 0.
REQ-021 Reset asserted mid-BURST SHALL return configId to IDLE_ID on the next cycle; partially loaded buffer contents SHALL be discarded.

Structure
REQ-022 A shared package config_seq_pkg SHALL hold the state enum, IDLE_ID and the record field widths.
REQ-023 Payload storage SHALL be one sub-module, config_byte_buffer: a write-pointer/read-pointer register array of MAX_PAYLOAD x 8 with synchronous clear.

Verification
REQ-024 Idle passthrough: tracing_req=1, no in_valid -> tracing=1 one cycle later; busy=0, configId=8'hFF.
REQ-025 Single record: tracing_req=0, stream {3, 20, 0x00..0x13, 0xFF} -> DRAIN_CYCLES=4 cycles of tracing=0 before in_ready rises; then 20 consecutive cycles configId=3 with configData=0x00..0x13; one IDLE_ID cycle; done pulse; busy falls.
REQ-026 Back-to-back same id: {5,2,0xAA,0xBB},{5,1,0xCC},{0xFF} -> bursts AA,BB then CC, separated by at least one configId=8'hFF cycle.
REQ-027 Bubbly load: insert in_valid=0 between every payload byte of {2,4,...} -> burst is still 4 contiguous cycles.
REQ-028 Errors: len=33 -> error=1, done pulse, no burst; len=0 -> no burst and the next header is accepted.
REQ-029 Reset in BURST after byte 2 of 10 -> configId=8'hFF next cycle, state IDLE, and a fresh session completes normally.
